// File: rtl/sev_seg_pkg.sv
// Shared glyph table and polarity helper
// for the seven-segment scan driver.
package sev_seg_pkg;

    // All segments dark, active-high view.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Active-high glyphs {A,B,C,D,E,F,G}; index = nibble.
    localparam logic [15:0][6:0] GLYPH = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

    // Map an active-high pattern onto the pin polarity.
    function automatic logic [6:0] seg_pol(
        input logic [6:0] g,
        input logic       low
    );
        return low ? ~g : g;
    endfunction

endpackage

// File: rtl/sev_seg_decode.sv
// Nibble to active-high seven-segment glyph.
// Purely combinational table lookup.
module sev_seg_decode
    import sev_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);

    assign glyph = GLYPH[nib];

endmodule

// File: rtl/sev_seg_scan_driver.sv
// Multiplexed common-anode display driver with blanking,
// leading-zero suppression and frame-synchronous updates.
module sev_seg_scan_driver
    import sev_seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK          = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic SL = (SEG_ACTIVE_LOW != 0);
    localparam logic AL = (AN_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF =
        AL ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   disp_val;
    logic [DIGITS-1:0]     disp_dp;
    logic [4*DIGITS-1:0]   pend_val;
    logic [DIGITS-1:0]     pend_dp;
    logic                  pend_valid;

    logic                  slot_end;
    logic                  boundary;
    logic                  in_blank;
    logic [DIGITS-1:0]     lz;
    logic                  zrun;
    logic [3:0]            nib;
    logic                  cur_dp;
    logic                  cur_lz;
    logic [DIGITS-1:0]     an_hot;
    logic [6:0]            glyph;
    logic [6:0]            lit;

    assign slot_end = (cnt == CW'(SCAN_DIV - 1));
    assign boundary = slot_end && (idx == IW'(DIGITS - 1));
    assign in_blank = (cnt < CW'(BLANK));

    // Slot timer and digit index; idx wrap marks the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            if (idx == IW'(DIGITS - 1))
                idx <= '0;
            else
                idx <= idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending/display double buffer, swapped only at frame edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_val   <= '0;
            disp_dp    <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (boundary) begin
            pend_valid <= 1'b0;
            if (load) begin
                disp_val <= value;
                disp_dp  <= dp_in;
            end else if (pend_valid) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
        end else if (load) begin
            pend_val   <= value;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
        end
    end

    // Digit k is a leading zero if it and all above are zero.
    always_comb begin
        lz   = '0;
        zrun = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zrun  = zrun & (disp_val[4*k +: 4] == 4'h0);
            lz[k] = zrun;
        end
    end

    // Select the nibble, dp and anode of the current slot.
    always_comb begin
        nib    = 4'h0;
        cur_dp = 1'b0;
        cur_lz = 1'b0;
        an_hot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib       = disp_val[4*k +: 4];
                cur_dp    = disp_dp[k];
                cur_lz    = lz[k];
                an_hot[k] = 1'b1;
            end
        end
    end

    sev_seg_decode u_dec (
        .nib   (nib),
        .glyph (glyph)
    );

    assign lit = (blank_lz && cur_lz) ? SEG_BLANK : glyph;

    // Pin register: polarity applied here, blanking gap first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= seg_pol(SEG_BLANK, SL);
            dp         <= SL;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (in_blank) begin
                seg <= seg_pol(SEG_BLANK, SL);
                dp  <= SL;
                an  <= AN_OFF;
            end else begin
                seg <= seg_pol(lit, SL);
                dp  <= cur_dp ^ SL;
                an  <= AL ? ~an_hot : an_hot;
            end
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Directed bench for sev_seg_scan_driver
// (4 digits, 8 clocks per slot, 2 blank clocks).
module tb_sev_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks;
    int errors;
    int ecount;

    sev_seg_scan_driver #(
        .DIGITS         (4),
        .SCAN_DIV       (8),
        .BLANK          (2),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Advance to edge e counted from reset release, sample at +1.
    task automatic to_edge(input int e);
        while (ecount < e) begin
            @(posedge clk);
            ecount++;
        end
        #1;
    endtask

    task automatic pins(
        input string      tag,
        input logic [3:0] ean,
        input logic [6:0] eseg
    );
        check({tag, ".an"}, 32'(an), 32'(ean));
        check({tag, ".seg"}, 32'(seg), 32'(eseg));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        ecount   = 0;
        rst      = 1'b1;
        value    = '0;
        dp_in    = '0;
        load     = 1'b0;
        blank_lz = 1'b0;

        // 1: reset and first slot timing
        repeat (3) @(posedge clk);
        #1;
        pins("rst", 4'b1111, 7'b1111111);
        check("rst.fd", 32'(frame_done), 32'd0);
        check("rst.dp", 32'(dp), 32'd1);
        rst    = 1'b0;
        ecount = 0;
        to_edge(1);  pins("e1", 4'b1111, 7'b1111111);
        to_edge(2);  pins("e2", 4'b1111, 7'b1111111);
        to_edge(3);  pins("e3", 4'b1110, 7'b0000001);
        to_edge(8);  pins("e8", 4'b1110, 7'b0000001);
        to_edge(9);  pins("e9", 4'b1111, 7'b1111111);
        to_edge(31); check("fd31", 32'(frame_done), 32'd0);
        to_edge(32); check("fd32", 32'(frame_done), 32'd1);
        to_edge(33); check("fd33", 32'(frame_done), 32'd0);

        // 2: load 12AF, visible only from the next frame
        to_edge(40);
        value = 16'h12AF;
        load  = 1'b1;
        to_edge(41);
        load  = 1'b0;
        to_edge(45); pins("old", 4'b1101, 7'b0000001);
        to_edge(67); pins("h0", 4'b1110, 7'b0111000);
        to_edge(73); pins("gap", 4'b1111, 7'b1111111);
        to_edge(75); pins("h1", 4'b1101, 7'b0001000);
        to_edge(83); pins("h2", 4'b1011, 7'b0010010);
        to_edge(91); pins("h3", 4'b0111, 7'b1001111);
        check("h3.dp", 32'(dp), 32'd1);

        // 3: leading-zero suppression on 0050
        to_edge(100);
        value    = 16'h0050;
        blank_lz = 1'b1;
        load     = 1'b1;
        to_edge(101);
        load     = 1'b0;
        to_edge(131); pins("z0", 4'b1110, 7'b0000001);
        to_edge(139); pins("z1", 4'b1101, 7'b0100100);
        to_edge(147); pins("z2", 4'b1011, 7'b1111111);
        to_edge(155); pins("z3", 4'b0111, 7'b1111111);

        // 3/5: value 0 with dp on digit 2
        to_edge(160);
        value = 16'h0000;
        dp_in = 4'b0100;
        load  = 1'b1;
        to_edge(161);
        load  = 1'b0;
        to_edge(195); pins("o0", 4'b1110, 7'b0000001);
        check("o0.dp", 32'(dp), 32'd1);
        to_edge(203); pins("o1", 4'b1101, 7'b1111111);
        to_edge(209); check("o2b.dp", 32'(dp), 32'd1);
        to_edge(211); pins("o2", 4'b1011, 7'b1111111);
        check("o2.dp", 32'(dp), 32'd0);
        to_edge(219); pins("o3", 4'b0111, 7'b1111111);
        check("o3.dp", 32'(dp), 32'd1);

        // 4: two loads in one frame, last wins
        to_edge(228);
        blank_lz = 1'b0;
        dp_in    = 4'b0000;
        value    = 16'h1111;
        load     = 1'b1;
        to_edge(229);
        load     = 1'b0;
        to_edge(235); pins("p1", 4'b1101, 7'b0000001);
        to_edge(240);
        value = 16'h2222;
        load  = 1'b1;
        to_edge(241);
        load  = 1'b0;
        to_edge(259); pins("w0", 4'b1110, 7'b0010010);
        to_edge(283); pins("w3", 4'b0111, 7'b0010010);

        // 4: load on the boundary cycle bypasses pending
        to_edge(287);
        value = 16'h3333;
        load  = 1'b1;
        to_edge(288);
        load  = 1'b0;
        to_edge(291); pins("b3", 4'b1110, 7'b0000110);
        to_edge(300);
        value = 16'h4444;
        load  = 1'b1;
        to_edge(301);
        load  = 1'b0;
        to_edge(319);
        value = 16'h5555;
        load  = 1'b1;
        to_edge(320);
        load  = 1'b0;
        to_edge(323); pins("b5", 4'b1110, 7'b0100100);
        to_edge(355); pins("b5n", 4'b1110, 7'b0100100);

        // 6: async reset in the middle of slot 2
        to_edge(372);
        pins("pre", 4'b1011, 7'b0100100);
        #2;
        rst = 1'b1;
        #1;
        pins("arst", 4'b1111, 7'b1111111);
        check("arst.dp", 32'(dp), 32'd1);
        check("arst.fd", 32'(frame_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        ecount = 0;
        to_edge(2);  pins("r2", 4'b1111, 7'b1111111);
        to_edge(3);  pins("r3", 4'b1110, 7'b0000001);
        to_edge(31); check("rfd31", 32'(frame_done), 32'd0);
        to_edge(32); check("rfd32", 32'(frame_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
